// File: rtl/yutorina_pipeline_controller_if.sv
// Control bundle between the yutorina pipeline controller and the datapath stages.
// The master side is the controller; the slave side is the datapath.
interface yutorina_pipeline_controller_if #(
  parameter int STAGE_COUNT    = 5,
  parameter int ADDR_WIDTH     = 30,
  parameter int EXC_CODE_WIDTH = 3
);
  logic [STAGE_COUNT-1:0]    stall_request;
  logic                      branch_taken;
  logic [ADDR_WIDTH-1:0]     branch_target;
  logic                      exception;
  logic [EXC_CODE_WIDTH-1:0] exception_code;
  logic [ADDR_WIDTH-1:0]     exception_pc;
  logic                      eret;
  logic                      halt;
  logic                      resume;
  logic [STAGE_COUNT-1:0]    stage_stall;
  logic [STAGE_COUNT-1:0]    stage_flush;
  logic [ADDR_WIDTH-1:0]     new_pc;
  logic                      new_pc_valid;
  logic [ADDR_WIDTH-1:0]     epc;
  logic [EXC_CODE_WIDTH-1:0] cause;
  logic                      register_write_enable_;
  logic [1:0]                state;

  modport master (
    input  stall_request, branch_taken, branch_target, exception, exception_code,
           exception_pc, eret, halt, resume,
    output stage_stall, stage_flush, new_pc, new_pc_valid, epc, cause,
           register_write_enable_, state
  );

  modport slave (
    output stall_request, branch_taken, branch_target, exception, exception_code,
           exception_pc, eret, halt, resume,
    input  stage_stall, stage_flush, new_pc, new_pc_valid, epc, cause,
           register_write_enable_, state
  );
endinterface

// File: rtl/yutorina_pipeline_controller.sv
// Pipeline controller for the yutorina core: stall/flush arbitration, PC redirection,
// exception PC/cause capture and the active-low register-file write enable.
module yutorina_pipeline_controller #(
  parameter int                    STAGE_COUNT    = 5,
  parameter int                    ADDR_WIDTH     = 30,
  parameter int                    EXC_CODE_WIDTH = 3,
  parameter int                    BRANCH_STAGE   = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR   = '0,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR     = ADDR_WIDTH'(1)
) (
  input logic clock,
  input logic reset,
  yutorina_pipeline_controller_if.master bus
);
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    FLUSH  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [STAGE_COUNT-1:0] ALL_STAGES  = '1;
  localparam logic [STAGE_COUNT-1:0] ERET_MASK   = ALL_STAGES >> (STAGE_COUNT - BRANCH_STAGE - 1);
  localparam logic [STAGE_COUNT-1:0] BRANCH_MASK = ALL_STAGES >> (STAGE_COUNT - BRANCH_STAGE);

  state_t                    state_reg, state_next;
  logic [ADDR_WIDTH-1:0]     epc_reg;
  logic [EXC_CODE_WIDTH-1:0] cause_reg;
  logic                      capture;

  logic [STAGE_COUNT-1:0]    stall_mask;
  logic [STAGE_COUNT-1:0]    stall_bubble;
  logic                      hold_redirect;

  logic [STAGE_COUNT-1:0]    stall;
  logic [STAGE_COUNT-1:0]    flush;
  logic [ADDR_WIDTH-1:0]     new_pc;
  logic                      new_pc_valid;
  logic                      write_enable_n;

  // Stage i is held when any stage at or beyond i requests a stall; the stage just
  // past the highest requester gets a bubble so it does not re-execute.
  genvar gi;
  generate
    for (gi = 0; gi < STAGE_COUNT; gi++) begin : g_stall
      assign stall_mask[gi] = |bus.stall_request[STAGE_COUNT-1:gi];
      if (gi == 0) begin : g_head
        assign stall_bubble[gi] = 1'b0;
      end else begin : g_tail
        assign stall_bubble[gi] = stall_mask[gi-1] & ~stall_mask[gi];
      end
    end
  endgenerate

  // A held branch stage keeps its branch/eret, which is presented again later.
  assign hold_redirect = stall_mask[BRANCH_STAGE];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= BOOT;
      epc_reg   <= '0;
      cause_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        epc_reg   <= bus.exception_pc;
        cause_reg <= bus.exception_code;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    capture        = 1'b0;
    stall          = '0;
    flush          = '0;
    new_pc         = '0;
    new_pc_valid   = 1'b0;
    write_enable_n = 1'b1;

    unique case (state_reg)
      BOOT: begin
        flush        = ALL_STAGES;
        new_pc       = RESET_VECTOR;
        new_pc_valid = 1'b1;
        state_next   = RUN;
      end
      FLUSH: begin
        flush        = ALL_STAGES;
        new_pc       = EXC_VECTOR;
        new_pc_valid = 1'b1;
        state_next   = RUN;
      end
      RUN: begin
        if (bus.exception) begin
          flush      = ALL_STAGES;
          capture    = 1'b1;
          state_next = FLUSH;
        end else begin
          stall = stall_mask;
          flush = stall_bubble;
          if (bus.eret && !hold_redirect) begin
            new_pc       = epc_reg;
            new_pc_valid = 1'b1;
            flush        = flush | ERET_MASK;
          end else if (bus.branch_taken && !hold_redirect) begin
            new_pc       = bus.branch_target;
            new_pc_valid = 1'b1;
            flush        = flush | BRANCH_MASK;
          end else if (bus.halt) begin
            state_next = HALTED;
          end
          write_enable_n = stall[STAGE_COUNT-1] | flush[STAGE_COUNT-1];
        end
      end
      HALTED: begin
        if (bus.exception) begin
          flush      = ALL_STAGES;
          capture    = 1'b1;
          state_next = FLUSH;
        end else begin
          stall = ALL_STAGES;
          if (bus.resume) begin
            state_next = RUN;
          end
        end
      end
      default: state_next = BOOT;
    endcase

    // Reset is asynchronous, so the outputs must reflect it before any edge arrives.
    if (reset) begin
      capture        = 1'b0;
      stall          = '0;
      flush          = ALL_STAGES;
      new_pc         = '0;
      new_pc_valid   = 1'b0;
      write_enable_n = 1'b1;
    end
  end

  assign bus.stage_stall            = stall;
  assign bus.stage_flush            = flush;
  assign bus.new_pc                 = new_pc;
  assign bus.new_pc_valid           = new_pc_valid;
  assign bus.epc                    = epc_reg;
  assign bus.cause                  = cause_reg;
  assign bus.register_write_enable_ = write_enable_n;
  assign bus.state                  = state_reg;
endmodule

// File: tb/tb_yutorina_pipeline_controller.sv
// Scoreboard bench for the yutorina pipeline controller: expected output snapshots
// are queued as stimulus is applied and compared on the falling clock edge.
module tb_yutorina_pipeline_controller;
  localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2, S_HALTED = 2'd3;

  typedef logic [76:0] snap_t;
  typedef struct {
    string name;
    snap_t v;
  } exp_t;

  logic  clock;
  logic  reset;
  exp_t  sb[$];
  exp_t  e;
  int    n_compared;
  int    n_mismatch;
  logic [29:0] model_epc;
  logic [2:0]  model_cause;

  yutorina_pipeline_controller_if #(.STAGE_COUNT(5), .ADDR_WIDTH(30), .EXC_CODE_WIDTH(3)) bus ();

  yutorina_pipeline_controller #(
    .STAGE_COUNT(5), .ADDR_WIDTH(30), .EXC_CODE_WIDTH(3), .BRANCH_STAGE(2),
    .RESET_VECTOR(30'd0), .EXC_VECTOR(30'd1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic snap_t mk(input logic [1:0] st, input logic wen, input logic vld,
                               input logic [29:0] pc, input logic [4:0] fl,
                               input logic [4:0] stl, input logic [29:0] ep,
                               input logic [2:0] ca);
    return {st, wen, vld, pc, fl, stl, ep, ca};
  endfunction

  function automatic snap_t observe();
    return {bus.state, bus.register_write_enable_, bus.new_pc_valid, bus.new_pc,
            bus.stage_flush, bus.stage_stall, bus.epc, bus.cause};
  endfunction

  task automatic idle();
    bus.stall_request  = '0;
    bus.branch_taken   = 1'b0;
    bus.branch_target  = '0;
    bus.exception      = 1'b0;
    bus.exception_code = '0;
    bus.exception_pc   = '0;
    bus.eret           = 1'b0;
    bus.halt           = 1'b0;
    bus.resume         = 1'b0;
  endtask

  task automatic push(input string name, input snap_t v);
    exp_t x;
    x.name = name;
    x.v    = v;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    push("reset_hold", mk(S_BOOT, 1'b1, 1'b0, 30'd0, 5'b11111, 5'b0, 30'd0, 3'd0));
    #1;
    e = sb.pop_front(); n_compared++;
    if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
    else $display("ok %s: %h", e.name, observe());
    @(negedge clock);
    reset = 1'b0;
    push("boot", mk(S_BOOT, 1'b1, 1'b1, 30'd0, 5'b11111, 5'b0, 30'd0, 3'd0));
    push("boot_to_run", mk(S_RUN, 1'b0, 1'b0, 30'd0, 5'b0, 5'b0, 30'd0, 3'd0));
    #1;
    e = sb.pop_front(); n_compared++;
    if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
    else $display("ok %s: %h", e.name, observe());
    @(negedge clock); #1;
    e = sb.pop_front(); n_compared++;
    if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
    else $display("ok %s: %h", e.name, observe());
    model_epc   = '0;
    model_cause = '0;
  endtask

  task automatic test_stall();
    logic [4:0] req, es, ef;
    int k;
    @(negedge clock);
    bus.stall_request = 5'b00100;
    push("stall_mid", mk(S_RUN, 1'b0, 1'b0, 30'd0, 5'b01000, 5'b00111, model_epc, model_cause));
    #1;
    e = sb.pop_front(); n_compared++;
    if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
    else $display("ok %s: %h", e.name, observe());
    @(negedge clock);
    bus.stall_request = 5'b10000;
    push("stall_wb", mk(S_RUN, 1'b1, 1'b0, 30'd0, 5'b00000, 5'b11111, model_epc, model_cause));
    #1;
    e = sb.pop_front(); n_compared++;
    if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
    else $display("ok %s: %h", e.name, observe());
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      req = 5'($urandom_range(1, 31));
      k = 0;
      for (int i = 0; i < 5; i++) if (req[i]) k = i;
      es = 5'b11111 >> (4 - k);
      ef = (k < 4) ? (5'b00001 << (k + 1)) : 5'b00000;
      bus.stall_request = req;
      push($sformatf("stall_rand_%05b", req),
           mk(S_RUN, es[4] | ef[4], 1'b0, 30'd0, ef, es, model_epc, model_cause));
      #1;
      e = sb.pop_front(); n_compared++;
      if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
      else $display("ok %s: %h", e.name, observe());
    end
    idle();
  endtask

  task automatic test_branch();
    @(negedge clock);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 30'h100;
    push("branch", mk(S_RUN, 1'b0, 1'b1, 30'h100, 5'b00011, 5'b0, model_epc, model_cause));
    #1;
    e = sb.pop_front(); n_compared++;
    if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
    else $display("ok %s: %h", e.name, observe());
    @(negedge clock);
    bus.stall_request = 5'b00100;
    push("branch_held", mk(S_RUN, 1'b0, 1'b0, 30'd0, 5'b01000, 5'b00111, model_epc, model_cause));
    #1;
    e = sb.pop_front(); n_compared++;
    if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
    else $display("ok %s: %h", e.name, observe());
    idle();
  endtask

  task automatic test_exception();
    @(negedge clock);
    bus.exception      = 1'b1;
    bus.exception_pc   = 30'h2A;
    bus.exception_code = 3'd5;
    bus.branch_taken   = 1'b1;
    bus.branch_target  = 30'h100;
    push("exc_cycle", mk(S_RUN, 1'b1, 1'b0, 30'd0, 5'b11111, 5'b0, model_epc, model_cause));
    model_epc   = 30'h2A;
    model_cause = 3'd5;
    push("exc_flush", mk(S_FLUSH, 1'b1, 1'b1, 30'd1, 5'b11111, 5'b0, model_epc, model_cause));
    push("exc_back_run", mk(S_RUN, 1'b0, 1'b0, 30'd0, 5'b0, 5'b0, model_epc, model_cause));
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        @(negedge clock);
        idle();
        if (c == 1) bus.halt = 1'b1;
      end
      #1;
      e = sb.pop_front(); n_compared++;
      if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
      else $display("ok %s: %h", e.name, observe());
    end
    idle();
  endtask

  task automatic test_eret();
    @(negedge clock);
    bus.eret = 1'b1;
    push("eret", mk(S_RUN, 1'b0, 1'b1, model_epc, 5'b00111, 5'b0, model_epc, model_cause));
    push("eret_held", mk(S_RUN, 1'b1, 1'b0, 30'd0, 5'b10000, 5'b01111, model_epc, model_cause));
    #1;
    e = sb.pop_front(); n_compared++;
    if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
    else $display("ok %s: %h", e.name, observe());
    @(negedge clock);
    bus.stall_request = 5'b01000;
    #1;
    e = sb.pop_front(); n_compared++;
    if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
    else $display("ok %s: %h", e.name, observe());
    idle();
  endtask

  task automatic test_halt();
    @(negedge clock);
    bus.halt = 1'b1;
    push("halt_req", mk(S_RUN, 1'b0, 1'b0, 30'd0, 5'b0, 5'b0, model_epc, model_cause));
    push("halted", mk(S_HALTED, 1'b1, 1'b0, 30'd0, 5'b0, 5'b11111, model_epc, model_cause));
    push("halted_resume", mk(S_HALTED, 1'b1, 1'b0, 30'd0, 5'b0, 5'b11111, model_epc, model_cause));
    push("resumed", mk(S_RUN, 1'b0, 1'b0, 30'd0, 5'b0, 5'b0, model_epc, model_cause));
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(negedge clock);
        idle();
        if (c == 2) bus.resume = 1'b1;
        if (c == 3) bus.halt = 1'b1;
      end
      #1;
      e = sb.pop_front(); n_compared++;
      if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
      else $display("ok %s: %h", e.name, observe());
    end
    // Exception while halted, with resume asserted alongside it.
    @(negedge clock);
    idle();
    bus.exception      = 1'b1;
    bus.resume         = 1'b1;
    bus.exception_pc   = 30'h33;
    bus.exception_code = 3'd6;
    push("halted_exc", mk(S_HALTED, 1'b1, 1'b0, 30'd0, 5'b11111, 5'b0, model_epc, model_cause));
    model_epc   = 30'h33;
    model_cause = 3'd6;
    push("halted_exc_flush", mk(S_FLUSH, 1'b1, 1'b1, 30'd1, 5'b11111, 5'b0, model_epc, model_cause));
    #1;
    e = sb.pop_front(); n_compared++;
    if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
    else $display("ok %s: %h", e.name, observe());
    @(negedge clock);
    idle();
    #1;
    e = sb.pop_front(); n_compared++;
    if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
    else $display("ok %s: %h", e.name, observe());
    // Reset in the middle of FLUSH returns to BOOT immediately and clears epc/cause.
    #1;
    reset = 1'b1;
    model_epc   = '0;
    model_cause = '0;
    push("reset_mid_flush", mk(S_BOOT, 1'b1, 1'b0, 30'd0, 5'b11111, 5'b0, 30'd0, 3'd0));
    #1;
    e = sb.pop_front(); n_compared++;
    if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
    else $display("ok %s: %h", e.name, observe());
    @(negedge clock);
    reset = 1'b0;
    push("reboot", mk(S_BOOT, 1'b1, 1'b1, 30'd0, 5'b11111, 5'b0, 30'd0, 3'd0));
    push("rerun", mk(S_RUN, 1'b0, 1'b0, 30'd0, 5'b0, 5'b0, 30'd0, 3'd0));
    #1;
    e = sb.pop_front(); n_compared++;
    if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
    else $display("ok %s: %h", e.name, observe());
    @(negedge clock); #1;
    e = sb.pop_front(); n_compared++;
    if (observe() !== e.v) begin n_mismatch++; $display("FAIL %s: got %h required %h", e.name, observe(), e.v); end
    else $display("ok %s: %h", e.name, observe());
  endtask

  initial begin
    n_compared = 0;
    n_mismatch = 0;
    test_reset();
    test_stall();
    test_branch();
    test_exception();
    test_eret();
    test_halt();
    n_compared++;
    if (sb.size() != 0) begin
      n_mismatch++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end
endmodule

// File: doc/yutorina_pipeline_controller.md
Name: yutorina_pipeline_controller

Overview:
Parametrised pipeline controller for the yutorina CPU core. It owns the per-stage stall and flush controls, PC redirection (boot, branch, exception, exception return), the exception PC and cause registers, and the active-low register-file write enable. It sits beside the datapath stages and is the single arbitration point for all control-flow events.

Parameters:
STAGE_COUNT, 5, number of pipeline stages; index 0 = fetch, STAGE_COUNT-1 = write-back; minimum 3.
ADDR_WIDTH, 30, width of the word-addressed PC.
EXC_CODE_WIDTH, 3, width of the exception cause code.
BRANCH_STAGE, 2, stage index that resolves branches; must be in 1..STAGE_COUNT-2.
RESET_VECTOR, 0, PC issued at boot.
EXC_VECTOR, 1, PC issued on an exception.

Ports:
clock  in  1  system clock; all state changes on its rising edge.
reset  in  1  asynchronous, active-high reset.
stall_request  in  STAGE_COUNT  per-stage stall request; bit i comes from stage i.
branch_taken  in  1  branch resolved taken in BRANCH_STAGE.
branch_target  in  ADDR_WIDTH  branch destination.
exception  in  1  exception raised this cycle.
exception_code  in  EXC_CODE_WIDTH  cause of the exception.
exception_pc  in  ADDR_WIDTH  PC of the faulting instruction.
eret  in  1  exception-return instruction at BRANCH_STAGE.
halt  in  1  halt request.
resume  in  1  leave the HALTED state.
stage_stall  out  STAGE_COUNT  hold the pipeline register of stage i.
stage_flush  out  STAGE_COUNT  replace the contents of stage i with a bubble.
new_pc  out  ADDR_WIDTH  redirect PC.
new_pc_valid  out  1  fetch must load new_pc.
epc  out  ADDR_WIDTH  saved exception PC.
cause  out  EXC_CODE_WIDTH  saved exception cause.
register_write_enable_  out  1  active-low register-file write enable.
state  out  2  FSM state: BOOT=0, RUN=1, FLUSH=2, HALTED=3.

Behaviour:
- Reset (asynchronous, active-high): state=BOOT, epc=0, cause=0. While reset is high the outputs are: stall=0, flush=all ones, new_pc_valid=0, register_write_enable_=1.
- All outputs except epc, cause and state are combinational from state and the inputs.
- BOOT: flush=all ones, stall=0, new_pc=RESET_VECTOR, new_pc_valid=1, write enable=1 (disabled). Next state is always RUN; all inputs are ignored.
- RUN, arbitration priority: exception > eret > branch_taken > halt > stall.
  - exception: this cycle flush=all ones and write enable=1. At the clock edge, epc<=exception_pc, cause<=exception_code, and the next state is FLUSH.
  - FLUSH lasts exactly one cycle: flush=all ones, new_pc=EXC_VECTOR, new_pc_valid=1, write enable=1, stall=0. Next state is RUN. All inputs are ignored during FLUSH.
  - eret (no exception): new_pc=epc, new_pc_valid=1, flush[0..BRANCH_STAGE]=1, other stages unaffected. Next state is RUN.
  - branch_taken: new_pc=branch_target, new_pc_valid=1, flush[0..BRANCH_STAGE-1]=1.
  - halt: at the clock edge the next state is HALTED. Stall handling applies during this cycle.
  - Stall: let k be the highest index with stall_request set. Then stall[0..k]=1, and flush[k+1]=1 if k+1<STAGE_COUNT.
  - If k>=BRANCH_STAGE, branch_taken and eret are ignored that cycle (new_pc_valid=0, no redirect flushes). The event is re-presented while the stage is held.
- register_write_enable_ in RUN is 0 unless stall or flush of stage STAGE_COUNT-1 is asserted that cycle, in which case it is 1.
- HALTED: stall=all ones, flush=0, write enable=1, new_pc_valid=0.
  - resume moves to RUN at the next edge.
  - exception in HALTED is handled exactly as in RUN: capture epc and cause, go to FLUSH, with priority over resume.
- new_pc is 0 whenever new_pc_valid=0.
- Reset asserted in any state, including mid-FLUSH, returns to BOOT immediately; epc and cause are cleared.

Test Plan:
- Reset pulse then release -> while reset high: flush=5'b11111, state=0. First cycle after release: new_pc=0, new_pc_valid=1, state=BOOT. Next cycle: state=RUN, register_write_enable_=0.
- RUN, stall_request=5'b00100 -> stage_stall=5'b00111, stage_flush=5'b01000, register_write_enable_=0. With stall_request=5'b10000: stall=5'b11111, flush=0, register_write_enable_=1.
- RUN, branch_taken=1, branch_target=0x100 -> same cycle new_pc=0x100, new_pc_valid=1, flush=5'b00011. Repeat with stall_request=5'b00100: new_pc_valid=0, no redirect.
- RUN, exception=1, exception_pc=0x2A, code=5, with branch_taken=1 in the same cycle -> flush=all ones, branch dropped. Next cycle: state=FLUSH, new_pc=1, epc=0x2A, cause=5. Cycle after: RUN.
- After the exception above, eret=1 -> new_pc=0x2A, new_pc_valid=1, flush=5'b00111.
- halt=1 -> next cycle HALTED with stall=all ones. Assert exception and resume together -> next state FLUSH, epc captured. Separately, asserting reset mid-FLUSH -> BOOT, epc=0.
